// File: rtl/float_to_screen_map_pipe.sv
// float_to_screen_map_pipe
//   Converts a pair of normalised IEEE-754 single-precision coordinates
//   (nominally [-1.0, 1.0]) into integer screen pixels:
//     pix = clamp(floor((f + 1.0) * DIM / 2), 0, DIM-1)
//   with an optional vertical flip and per-lane out-of-range flags.
//   Four register stages with a global stall; latency 4, throughput 1/cycle.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready is combinational)
//   in_x, in_y              IEEE-754 single coordinates
//   out_valid / out_ready   output handshake
//   pix_x [XW], pix_y [YW]  pixel coordinates (pix_y after optional flip)
//   oor_x, oor_y            lane was out of [-1,1], NaN or Inf

// Per-lane datapath. Every register advances on adv_i and holds otherwise.
//   S1 decode -> Q3.FRAC signed, S2 +1.0, S3 *DIM, S4 floor/clamp/flip.
module float_to_screen_map_lane #(
    parameter int DIM  = 320,
    parameter int FRAC = 16,
    parameter int FLIP = 0,
    parameter int W    = $clog2(DIM)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         adv_i,
    input  logic [31:0]  f_i,
    output logic [W-1:0] pix_o,
    output logic         oor_o
);
    localparam int QW = FRAC + 3;            // signed Q3.FRAC (|q| < 4.0)
    localparam int TW = FRAC + 4;            // signed Q4.FRAC (t in (-3, 5))
    localparam int DW = $clog2(DIM) + 2;     // DIM as a signed operand
    localparam int PW = TW + DW;

    localparam logic        [FRAC+1:0] MAG_MAX = '1;  // 4.0 - lsb
    localparam logic signed [TW-1:0]   ONE     = TW'(1) << FRAC;
    localparam logic signed [TW-1:0]   TWO     = TW'(2) << FRAC;
    localparam logic signed [PW-1:0]   DIM_S   = PW'(DIM);
    localparam logic signed [PW-1:0]   PMAX    = PW'(DIM - 1);
    localparam logic        [W-1:0]    PIX_MAX = W'(DIM - 1);
    localparam logic signed [9:0]      EMIN    = 10'(-FRAC);
    localparam logic signed [9:0]      SH0     = 10'(24 - FRAC);

    // ---------------- S1: decode ----------------
    logic [7:0]             exp_w;
    logic signed [9:0]      e_w, sh_w;
    logic [FRAC+1:0]        mag_w;
    logic signed [QW-1:0]   mag_s_w, q_d, q_q;
    logic                   neg_w, spec_d, spec_q;

    assign exp_w = f_i[30:23];
    assign e_w   = $signed({2'b00, exp_w}) - 10'sd127;
    // {1.mant, 0} carries 1.mant * 2^24; shifting right by 24-FRAC-e
    // lands it in Q.FRAC units, truncating the low bits.
    assign sh_w  = SH0 - e_w;

    always_comb begin
        mag_w  = '0;
        spec_d = 1'b0;
        neg_w  = f_i[31];
        if (exp_w == 8'd0) begin
            mag_w = '0;
        end else if (exp_w == 8'hFF) begin
            // NaN is steered negative so it floors to pixel 0 like -Inf.
            spec_d = 1'b1;
            mag_w  = MAG_MAX;
            neg_w  = f_i[31] | (|f_i[22:0]);
        end else if (e_w >= 10'sd2) begin
            mag_w = MAG_MAX;
        end else if (e_w < EMIN) begin
            mag_w = '0;
        end else begin
            mag_w = (FRAC+2)'({1'b1, f_i[22:0], 1'b0} >> sh_w);
        end
    end

    assign mag_s_w = $signed({1'b0, mag_w});
    assign q_d     = neg_w ? -mag_s_w : mag_s_w;

    // ---------------- S2: t = q + 1.0 ----------------
    logic signed [TW-1:0] t_d, t_q;
    logic                 oor2_d, oor2_q;

    assign t_d    = $signed({q_q[QW-1], q_q}) + ONE;
    assign oor2_d = spec_q | t_d[TW-1] | (t_d > TWO);

    // ---------------- S3: prod = t * DIM ----------------
    logic signed [PW-1:0] prod_d, prod_q;
    logic                 oor3_q;

    assign prod_d = $signed({{DW{t_q[TW-1]}}, t_q}) * DIM_S;

    // ---------------- S4: floor, clamp, flip ----------------
    logic signed [PW-1:0] p_w;
    logic [W-1:0]         clamp_w, pix_d, pix_q;
    logic                 oor4_q;

    assign p_w = prod_q >>> (FRAC + 1);

    always_comb begin
        clamp_w = p_w[W-1:0];
        if (p_w[PW-1])
            clamp_w = '0;
        else if (p_w > PMAX)
            clamp_w = PIX_MAX;
    end

    assign pix_d = (FLIP != 0) ? PIX_MAX - clamp_w : clamp_w;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q    <= '0;
            spec_q <= 1'b0;
            t_q    <= '0;
            oor2_q <= 1'b0;
            prod_q <= '0;
            oor3_q <= 1'b0;
            pix_q  <= '0;
            oor4_q <= 1'b0;
        end else if (adv_i) begin
            q_q    <= q_d;
            spec_q <= spec_d;
            t_q    <= t_d;
            oor2_q <= oor2_d;
            prod_q <= prod_d;
            oor3_q <= oor2_q;
            pix_q  <= pix_d;
            oor4_q <= oor3_q;
        end
    end

    assign pix_o = pix_q;
    assign oor_o = oor4_q;
endmodule

module float_to_screen_map_pipe #(
    parameter int DIM_X  = 320,
    parameter int DIM_Y  = 180,
    parameter int FRAC   = 16,
    parameter int FLIP_Y = 1,
    parameter int XW     = $clog2(DIM_X),
    parameter int YW     = $clog2(DIM_Y)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_x,
    input  logic [31:0]   in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          oor_x,
    output logic          oor_y
);
    localparam int STAGES = 4;

    logic [STAGES-1:0] vld_d, vld_q;

    // Global stall: the whole pipe only moves when the output slot frees.
    assign in_ready  = !(out_valid && !out_ready);
    assign out_valid = vld_q[STAGES-1];
    assign vld_d     = {vld_q[STAGES-2:0], in_valid};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            vld_q <= '0;
        else if (in_ready)
            vld_q <= vld_d;
    end

    float_to_screen_map_lane #(
        .DIM(DIM_X), .FRAC(FRAC), .FLIP(0), .W(XW)
    ) u_lane_x (
        .clk_i(clk_in), .rst_n_i(rst_n_in), .adv_i(in_ready),
        .f_i(in_x), .pix_o(pix_x), .oor_o(oor_x)
    );

    float_to_screen_map_lane #(
        .DIM(DIM_Y), .FRAC(FRAC), .FLIP(FLIP_Y), .W(YW)
    ) u_lane_y (
        .clk_i(clk_in), .rst_n_i(rst_n_in), .adv_i(in_ready),
        .f_i(in_y), .pix_o(pix_y), .oor_o(oor_y)
    );
endmodule

// File: tb/tb_float_to_screen_map_pipe.sv
// Bench for float_to_screen_map_pipe (default parameters, FLIP_Y=1).
// Table vectors carry the unflipped y pixel; the flip is applied here.
module tb_float_to_screen_map_pipe;
    localparam int DX = 320, DY = 180, FR = 16, FL = 1;
    localparam int XW = 9, YW = 8;

    logic          clk_in = 1'b0, rst_n_in = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0]   in_x = '0, in_y = '0;
    logic          in_ready, out_valid, oor_x, oor_y;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    float_to_screen_map_pipe dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .pix_x(pix_x), .pix_y(pix_y), .oor_x(oor_x), .oor_y(oor_y)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: value-level reading of the conversion rules.
    function automatic void model(input logic [31:0] f, input int dim, input bit flip,
                                  output int pix, output bit oor);
        int     ex   = int'(f[30:23]);
        longint one  = longint'(1) << FR;
        longint q, t;
        real    mag;
        if (ex == 255) begin
            oor = 1'b1;
            pix = (f[22:0] == 0 && !f[31]) ? dim - 1 : 0;
        end else begin
            if (ex == 0) q = 0;
            else begin
                mag = real'(longint'(f[22:0]) + 64'd8388608) * (2.0 ** (ex - 150));
                if (mag >= 4.0) q = 4 * one - 1;
                else q = longint'($floor(mag * real'(one)));
                if (f[31]) q = -q;
            end
            t   = q + one;
            oor = (t < 0) || (t > 2 * one);
            pix = int'($floor(real'(t) * real'(dim) / real'(2 * one)));
            if (pix < 0) pix = 0;
            if (pix > dim - 1) pix = dim - 1;
        end
        if (flip) pix = dim - 1 - pix;
    endfunction

    function automatic logic [31:0] rnd_in(input bit wide);
        int r = $urandom_range(0, 99);
        logic [7:0]  e;
        logic [22:0] m = 23'($urandom);
        if (!wide) begin
            e = 8'($urandom_range(112, 126));
            if (r < 6) begin e = 8'd127; m = '0; end
        end else if (r < 3) begin
            e = 8'hFF; m = '0;
        end else if (r < 6) begin
            e = 8'hFF;
        end else if (r < 10) begin
            e = 8'd0;
        end else begin
            e = 8'($urandom_range(100, 129));
        end
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // One isolated transaction: latency and result.
    task automatic send_check(input string nm, input logic [31:0] x, input logic [31:0] y,
                              input int epx, input int epy, input bit eox, input bit eoy);
        int n;
        @(posedge clk_in); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_x = x; in_y = y;
        @(posedge clk_in); #1;
        in_valid = 1'b0; n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk_in); #1; n++;
        end
        chk({nm, ".latency"}, n, 4);
        chk({nm, ".pix_x"}, pix_x, epx);
        chk({nm, ".pix_y"}, pix_y, epy);
        chk({nm, ".oor_x"}, oor_x, eox);
        chk({nm, ".oor_y"}, oor_y, eoy);
    endtask

    typedef struct { int px; int py; bit ox; bit oy; } res_t;

    // Streams n pairs under backpressure; pat=1 gives out_ready 0,0,1 repeating.
    task automatic stream(input string nm, input int n, input bit wide, input bit pat);
        res_t q[$];
        res_t e, h;
        bit   held = 1'b0;
        int   sent = 0, recv = 0, cyc = 0;
        logic [31:0] cx, cy;
        cx = rnd_in(wide); cy = rnd_in(wide);
        while (recv < n && cyc < n * 10 + 50) begin
            @(posedge clk_in); #1;
            out_ready = pat ? (cyc % 3 == 2) : ($urandom_range(0, 3) != 0);
            in_valid  = (sent < n);
            in_x = cx; in_y = cy;
            #1;
            chk({nm, ".in_ready"}, in_ready, !(out_valid && !out_ready));
            if (held) begin
                chk({nm, ".hold_valid"}, out_valid, 1);
                chk({nm, ".hold_pix_x"}, pix_x, h.px);
                chk({nm, ".hold_pix_y"}, pix_y, h.py);
                chk({nm, ".hold_oor"}, {oor_x, oor_y}, {h.ox, h.oy});
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) chk({nm, ".unexpected_out"}, 1, 0);
                    else begin
                        e = q.pop_front();
                        chk({nm, ".pix_x"}, pix_x, e.px);
                        chk({nm, ".pix_y"}, pix_y, e.py);
                        chk({nm, ".oor_x"}, oor_x, e.ox);
                        chk({nm, ".oor_y"}, oor_y, e.oy);
                    end
                    recv++;
                end else begin
                    h = '{int'(pix_x), int'(pix_y), oor_x, oor_y};
                    held = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                model(cx, DX, 1'b0, e.px, e.ox);
                model(cy, DY, FL[0], e.py, e.oy);
                q.push_back(e);
                sent++;
                cx = rnd_in(wide); cy = rnd_in(wide);
            end
            cyc++;
        end
        chk({nm, ".received"}, recv, n);
        @(posedge clk_in); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        chk({nm, ".drained"}, out_valid, 0);
        chk({nm, ".leftover"}, q.size(), 0);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] x, y;
        int          px, py_raw;
        bit          ox, oy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit seen;
        tbl[0]  = '{"zero_half",   32'h00000000, 32'h3F000000, 160, 135, 0, 0};
        tbl[1]  = '{"m1_p1",       32'hBF800000, 32'h3F800000,   0, 179, 0, 0};
        tbl[2]  = '{"p2_m3",       32'h40000000, 32'hC0400000, 319,   0, 1, 1};
        tbl[3]  = '{"nan_pinf",    32'h7FC00000, 32'h7F800000,   0, 179, 1, 1};
        tbl[4]  = '{"denorm_mz",   32'h00000001, 32'h80000000, 160,  90, 0, 0};
        tbl[5]  = '{"mz_ndenorm",  32'h80000000, 32'h807FFFFF, 160,  90, 0, 0};
        tbl[6]  = '{"m0999_minf",  32'hBF7FBE77, 32'hFF800000,   0,   0, 0, 1};
        // 0.99375 rounds to a single just below 159/160, so floor gives 318.
        tbl[7]  = '{"p099375",     32'h3F7E6666, 32'h00000000, 318,  90, 0, 0};
        tbl[8]  = '{"p099",        32'h3F7D70A4, 32'h00000000, 318,  90, 0, 0};
        tbl[9]  = '{"p09938",      32'h3F7E69AD, 32'h3F800000, 319, 179, 0, 0};
        tbl[10] = '{"pinf_nan",    32'h7F800000, 32'h7FC00000, 319,   0, 1, 1};
        tbl[11] = '{"p4_m4",       32'h40800000, 32'hC0800000, 319,   0, 1, 1};
        // 2^-16 is one lsb: x stays on 160, -2^-16 pulls y just under 90.
        tbl[12] = '{"lsb_edges",   32'h37800000, 32'hB7800000, 160,  89, 0, 0};

        // Asynchronous reset with no clock edge involved.
        #2 rst_n_in = 1'b0;
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.pix", {pix_x, pix_y}, 0);
        chk("reset.oor", {oor_x, oor_y}, 0);
        chk("reset.in_ready", in_ready, 1);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in) rst_n_in = 1'b1;

        for (int i = 0; i < 13; i++)
            send_check(tbl[i].nm, tbl[i].x, tbl[i].y, tbl[i].px,
                       FL ? DY - 1 - tbl[i].py_raw : tbl[i].py_raw, tbl[i].ox, tbl[i].oy);

        stream("bp8", 8, 1'b0, 1'b1);
        stream("rnd", 200, 1'b1, 1'b0);

        // Reset with the output stalled and three more pairs behind it.
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = rnd_in(1'b0); in_y = rnd_in(1'b0);
            @(posedge clk_in); #1;
        end
        in_valid = 1'b0;
        chk("rst_mid.pre_valid", out_valid, 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("rst_mid.out_valid", out_valid, 0);
        chk("rst_mid.oor", {oor_x, oor_y}, 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) rst_n_in = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk_in); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_mid.no_output", seen, 0);
        send_check("post_rst", 32'h00000000, 32'h3F000000, 160, 44, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
